// File: rtl/pu_inst_buf_if.sv
// Chunk write bus from the path parser plus the replay stream and occupancy feedback.
interface pu_inst_buf_if #(
  parameter int unsigned DATA_NBITS       = 128,
  parameter int unsigned VB_NBITS         = 4,
  parameter int unsigned INST_DEPTH_NBITS = 6,
  parameter int unsigned LOC_NBITS        = 10
);
  logic                      pp_pu_valid;
  logic                      pp_pu_sop;
  logic                      pp_pu_eop;
  logic [DATA_NBITS-1:0]     pp_pu_data;
  logic [VB_NBITS-1:0]       pp_pu_valid_bytes;
  logic [LOC_NBITS-1:0]      pp_pu_pd_loc;
  logic                      pp_pu_inst_pd;
  logic [INST_DEPTH_NBITS:0] pu_pp_inst_buf_fifo_count;

  logic                      pu_valid;
  logic                      pu_ready;
  logic                      pu_sop;
  logic                      pu_eop;
  logic [DATA_NBITS-1:0]     pu_data;
  logic [VB_NBITS-1:0]       pu_valid_bytes;
  logic                      pu_inst_pd;
  logic [LOC_NBITS-1:0]      pu_pd_loc;

  modport master (
    output pp_pu_valid, pp_pu_sop, pp_pu_eop, pp_pu_data, pp_pu_valid_bytes,
           pp_pu_pd_loc, pp_pu_inst_pd, pu_ready,
    input  pu_pp_inst_buf_fifo_count, pu_valid, pu_sop, pu_eop, pu_data,
           pu_valid_bytes, pu_inst_pd, pu_pd_loc
  );

  modport slave (
    input  pp_pu_valid, pp_pu_sop, pp_pu_eop, pp_pu_data, pp_pu_valid_bytes,
           pp_pu_pd_loc, pp_pu_inst_pd, pu_ready,
    output pu_pp_inst_buf_fifo_count, pu_valid, pu_sop, pu_eop, pu_data,
           pu_valid_bytes, pu_inst_pd, pu_pd_loc
  );
endinterface

// File: rtl/pu_inst_buf.sv
// Instruction/PD chunk buffer: stores path-parser chunks and replays each complete
// packet to the processing unit as its instruction chunk followed by its PD chunk.

// Power-of-two FIFO; the count MSB is the full flag, writes to a full FIFO are dropped.
module pu_inst_buf_fifo #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH_NBITS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata_c,
  output logic [DEPTH_NBITS:0] count,
  output logic                 drop_c
);
  localparam int unsigned DEPTH     = 1 << DEPTH_NBITS;
  localparam int unsigned CNT_NBITS = DEPTH_NBITS + 1;

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH_NBITS-1:0] wr_ptr;
  logic [DEPTH_NBITS-1:0] rd_ptr;
  logic                   full_c;
  logic                   do_push_c;
  logic                   do_pop_c;

  assign full_c    = count[DEPTH_NBITS];
  assign do_push_c = push & ~full_c;
  assign do_pop_c  = pop & (count != '0);
  assign drop_c    = push & full_c;
  assign rdata_c   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + DEPTH_NBITS'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + DEPTH_NBITS'(1);
      count <= count + CNT_NBITS'(do_push_c) - CNT_NBITS'(do_pop_c);
    end
  end
endmodule

module pu_inst_buf #(
  parameter int unsigned DATA_NBITS       = 128,
  parameter int unsigned VB_NBITS         = 4,
  parameter int unsigned INST_DEPTH_NBITS = 6,
  parameter int unsigned PD_DEPTH_NBITS   = 5,
  parameter int unsigned DESC_DEPTH_NBITS = 2,
  parameter int unsigned LOC_NBITS        = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  pu_inst_buf_if.slave       bus,
  output logic               err_inst_ovf,
  output logic               err_pd_ovf,
  output logic               err_desc_ovf
);
  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [VB_NBITS-1:0]   vb;
    logic [DATA_NBITS-1:0] data;
  } word_t;

  localparam int unsigned WORD_NBITS     = $bits(word_t);
  localparam int unsigned INST_CNT_NBITS = INST_DEPTH_NBITS + 1;
  localparam int unsigned PD_CNT_NBITS   = PD_DEPTH_NBITS + 1;
  localparam int unsigned DESC_CNT_NBITS = DESC_DEPTH_NBITS + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_INST, ST_PD} state_e;

  state_e                    state_q;
  state_e                    state_d;
  word_t                     wr_word;
  word_t                     inst_head;
  word_t                     pd_head;
  word_t                     out_q;
  word_t                     out_d;
  logic [LOC_NBITS-1:0]      wr_loc_q;
  logic [LOC_NBITS-1:0]      desc_head;
  logic [LOC_NBITS-1:0]      loc_q;
  logic [LOC_NBITS-1:0]      loc_d;
  logic [INST_CNT_NBITS-1:0] inst_count;
  logic [PD_CNT_NBITS-1:0]   pd_count;
  logic [DESC_CNT_NBITS-1:0] desc_count;
  logic                      inst_push;
  logic                      pd_push;
  logic                      desc_push;
  logic                      inst_pop;
  logic                      pd_pop;
  logic                      desc_pop;
  logic                      inst_drop_c;
  logic                      pd_drop_c;
  logic                      desc_drop_c;
  logic                      inst_empty_c;
  logic                      pd_empty_c;
  logic                      desc_empty_c;
  logic                      valid_q;
  logic                      valid_d;
  logic                      inst_pd_q;
  logic                      inst_pd_d;
  logic                      ld_c;

  // Write-side routing; a descriptor exists only once the PD eop word is actually stored.
  assign wr_word   = {bus.pp_pu_sop, bus.pp_pu_eop, bus.pp_pu_valid_bytes, bus.pp_pu_data};
  assign inst_push = bus.pp_pu_valid & bus.pp_pu_inst_pd;
  assign pd_push   = bus.pp_pu_valid & ~bus.pp_pu_inst_pd;
  assign desc_push = pd_push & bus.pp_pu_eop & ~pd_drop_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_loc_q <= '0;
    end else if (inst_push && bus.pp_pu_sop && !inst_drop_c) begin
      wr_loc_q <= bus.pp_pu_pd_loc;
    end
  end

  pu_inst_buf_fifo #(.WIDTH(WORD_NBITS), .DEPTH_NBITS(INST_DEPTH_NBITS)) u_inst_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (inst_push),
    .pop     (inst_pop),
    .wdata   (wr_word),
    .rdata_c (inst_head),
    .count   (inst_count),
    .drop_c  (inst_drop_c)
  );

  pu_inst_buf_fifo #(.WIDTH(WORD_NBITS), .DEPTH_NBITS(PD_DEPTH_NBITS)) u_pd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (pd_push),
    .pop     (pd_pop),
    .wdata   (wr_word),
    .rdata_c (pd_head),
    .count   (pd_count),
    .drop_c  (pd_drop_c)
  );

  pu_inst_buf_fifo #(.WIDTH(LOC_NBITS), .DEPTH_NBITS(DESC_DEPTH_NBITS)) u_desc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (desc_push),
    .pop     (desc_pop),
    .wdata   (wr_loc_q),
    .rdata_c (desc_head),
    .count   (desc_count),
    .drop_c  (desc_drop_c)
  );

  assign inst_empty_c = (inst_count == '0);
  assign pd_empty_c   = (pd_count == '0);
  assign desc_empty_c = (desc_count == '0);

  // Output stage may load whenever it is empty or its word is being taken this cycle.
  assign ld_c = ~valid_q | bus.pu_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      inst_pd_q <= 1'b0;
      out_q     <= '0;
      loc_q     <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      inst_pd_q <= inst_pd_d;
      out_q     <= out_d;
      loc_q     <= loc_d;
    end
  end

  // Fetch FSM: pops the next word into the output register; a new descriptor is only
  // taken once the previous packet's last word has left, so pu_pd_loc never changes under a valid word.
  always_comb begin
    state_d   = state_q;
    valid_d   = ~ld_c;
    inst_pd_d = inst_pd_q;
    out_d     = out_q;
    loc_d     = loc_q;
    inst_pop  = 1'b0;
    pd_pop    = 1'b0;
    desc_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_c && !desc_empty_c) begin
          loc_d   = desc_head;
          state_d = ST_INST;
        end
      end
      ST_INST: begin
        if (ld_c && !inst_empty_c) begin
          inst_pop  = 1'b1;
          valid_d   = 1'b1;
          inst_pd_d = 1'b1;
          out_d     = inst_head;
          if (inst_head.eop) state_d = ST_PD;
        end
      end
      ST_PD: begin
        if (ld_c && !pd_empty_c) begin
          pd_pop    = 1'b1;
          valid_d   = 1'b1;
          inst_pd_d = 1'b0;
          out_d     = pd_head;
          if (pd_head.eop) begin
            desc_pop = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.pu_valid                  = valid_q;
  assign bus.pu_sop                    = out_q.sop;
  assign bus.pu_eop                    = out_q.eop;
  assign bus.pu_valid_bytes            = out_q.vb;
  assign bus.pu_data                   = out_q.data;
  assign bus.pu_inst_pd                = inst_pd_q;
  assign bus.pu_pd_loc                 = loc_q;
  assign bus.pu_pp_inst_buf_fifo_count = inst_count;

  // Sticky overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_inst_ovf <= 1'b0;
      err_pd_ovf   <= 1'b0;
      err_desc_ovf <= 1'b0;
    end else begin
      err_inst_ovf <= err_inst_ovf | inst_drop_c;
      err_pd_ovf   <= err_pd_ovf | pd_drop_c;
      err_desc_ovf <= err_desc_ovf | (desc_push & desc_drop_c);
    end
  end
endmodule
